// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: shared PC width, FSM states and BTB entry layout for the fetch unit
package pc_fetch_unit_pkg;
  localparam int XLEN = 32;
  localparam int INST_BYTES = 4;
  typedef logic [XLEN-1:0] pc_t;
  typedef enum logic [1:0] {BOOT, RUN, HALT} pc_state_e;
  typedef struct packed {
    logic valid;
    pc_t  tag;
    pc_t  target;
  } btb_entry_t;
endpackage

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: fetch-unit control, redirect, BTB-update and PC output bundle
// master: drives EN/PCSrcE/PCTargetE/trap_*/halt_i/resume_i/upd_*, reads PCF/PCPlus4F/status
// slave:  the fetch unit side of the same signals
interface pc_fetch_unit_if;
  import pc_fetch_unit_pkg::*;
  logic EN, PCSrcE, trap_i, halt_i, resume_i, upd_valid_i, upd_taken_i;
  pc_t  PCTargetE, trap_vec_i, upd_pc_i, upd_tgt_i;
  pc_t  PCF, PCPlus4F;
  logic fetch_vld_o, pred_taken_o, misalign_o, halted_o;
  modport master (
    output EN, PCSrcE, PCTargetE, trap_i, trap_vec_i, halt_i, resume_i,
           upd_valid_i, upd_pc_i, upd_tgt_i, upd_taken_i,
    input  PCF, PCPlus4F, fetch_vld_o, pred_taken_o, misalign_o, halted_o
  );
  modport slave (
    input  EN, PCSrcE, PCTargetE, trap_i, trap_vec_i, halt_i, resume_i,
           upd_valid_i, upd_pc_i, upd_tgt_i, upd_taken_i,
    output PCF, PCPlus4F, fetch_vld_o, pred_taken_o, misalign_o, halted_o
  );
endinterface

// File: rtl/pc_fetch_unit_btb.sv
// pc_fetch_unit_btb: direct-mapped branch target buffer with combinational lookup
// clk/rst: clock, sync active-high reset (clears valid bits)
// i_pc: lookup PC; o_hit/o_tgt: valid tag match and predicted target
// i_upd_*: resolved-branch update; taken writes the entry, not-taken with tag match invalidates
module pc_fetch_unit_btb import pc_fetch_unit_pkg::*; #(
  parameter int BTB_ENTRIES = 8
) (
  input  logic clk,
  input  logic rst,
  input  pc_t  i_pc,
  input  logic i_upd_valid,
  input  pc_t  i_upd_pc,
  input  pc_t  i_upd_tgt,
  input  logic i_upd_taken,
  output logic o_hit,
  output pc_t  o_tgt
);
  localparam int IW = $clog2(BTB_ENTRIES);
  btb_entry_t r_mem [BTB_ENTRIES];
  logic [IW-1:0] w_ri, w_ui;
  pc_t w_rtag, w_utag;
  assign w_ri = i_pc[IW+1:2];
  assign w_ui = i_upd_pc[IW+1:2];
  assign w_rtag = i_pc >> (IW + 2);
  assign w_utag = i_upd_pc >> (IW + 2);
  // Writes land on the edge, so a same-cycle lookup still sees the old entry.
  assign o_hit = r_mem[w_ri].valid && (r_mem[w_ri].tag == w_rtag);
  assign o_tgt = r_mem[w_ri].target;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) r_mem[i].valid <= 1'b0;
    end else if (i_upd_valid && i_upd_taken) begin
      r_mem[w_ui] <= '{valid: 1'b1, tag: w_utag, target: i_upd_tgt};
    end else if (i_upd_valid && (r_mem[w_ui].tag == w_utag)) begin
      r_mem[w_ui].valid <= 1'b0;
    end
  end
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch-stage PC generator with priority next-PC mux and debug halt FSM
// CLK/reset: clock, synchronous active-high reset
// bus (slave): EN, PCSrcE/PCTargetE, trap_i/trap_vec_i, halt_i/resume_i, upd_* in;
//              PCF, PCPlus4F, fetch_vld_o, pred_taken_o, misalign_o, halted_o out
// Build option PC_BTB_EN: adds a BTB_ENTRIES-deep direct-mapped BTB; otherwise no prediction.
module pc_fetch_unit import pc_fetch_unit_pkg::*; #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              BTB_ENTRIES  = 8
) (
  input logic CLK,
  input logic reset,
  pc_fetch_unit_if.slave bus
);
  logic [XLEN-1:0] r_pcf, w_next_pc, w_plus4, w_pred_tgt, w_trap_tgt, w_redir_tgt;
  pc_state_e r_state, w_next_state;
  logic r_mis, w_mis, w_hit;
  assign w_plus4 = r_pcf + XLEN'(INST_BYTES);
  assign w_trap_tgt = {bus.trap_vec_i[XLEN-1:2], 2'b00};
  assign w_redir_tgt = {bus.PCTargetE[XLEN-1:2], 2'b00};
`ifdef PC_BTB_EN
  pc_fetch_unit_btb #(.BTB_ENTRIES(BTB_ENTRIES)) u_btb (
    .clk(CLK),
    .rst(reset),
    .i_pc(r_pcf),
    .i_upd_valid(bus.upd_valid_i),
    .i_upd_pc(bus.upd_pc_i),
    .i_upd_tgt(bus.upd_tgt_i),
    .i_upd_taken(bus.upd_taken_i),
    .o_hit(w_hit),
    .o_tgt(w_pred_tgt)
  );
`else
  logic w_unused;
  assign w_unused = ^{bus.upd_valid_i, bus.upd_pc_i, bus.upd_tgt_i, bus.upd_taken_i, BTB_ENTRIES[0]};
  assign w_hit = 1'b0;
  assign w_pred_tgt = '0;
`endif
  // Trap, then redirect, always load (even stalled or halted); halt and stall only hold PCF.
  always_comb begin
    w_next_state = r_state;
    w_next_pc = r_pcf;
    w_mis = 1'b0;
    if (r_state == BOOT) begin
      w_next_state = RUN;
    end else if (bus.trap_i) begin
      w_next_pc = w_trap_tgt;
      w_mis = |bus.trap_vec_i[1:0];
    end else begin
      if (bus.PCSrcE) begin
        w_next_pc = w_redir_tgt;
        w_mis = |bus.PCTargetE[1:0];
      end
      if (r_state == RUN) begin
        if (!bus.PCSrcE && bus.halt_i) w_next_state = HALT;
        else if (!bus.PCSrcE && bus.EN) w_next_pc = w_hit ? w_pred_tgt : w_plus4;
      end else if (bus.resume_i) begin
        w_next_state = RUN;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_pcf <= RESET_VECTOR;
      r_state <= BOOT;
      r_mis <= 1'b0;
    end else begin
      r_pcf <= w_next_pc;
      r_state <= w_next_state;
      r_mis <= w_mis;
    end
  end
  assign bus.PCF = r_pcf;
  assign bus.PCPlus4F = w_plus4;
  assign bus.fetch_vld_o = (r_state == RUN) && bus.EN;
  assign bus.pred_taken_o = w_hit;
  assign bus.misalign_o = r_mis;
  assign bus.halted_o = (r_state == HALT);
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scenarios plus randomized run against a behavioural fetch model
module tb_pc_fetch_unit;
  localparam int N = 8;
`ifdef PC_BTB_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  pc_fetch_unit_if bus();
  pc_fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .BTB_ENTRIES(N)) dut (
    .CLK(clk), .reset(reset), .bus(bus)
  );
  int n_checks = 0;
  int n_errors = 0;
  // Model: mode 0 = booting, 1 = running, 2 = halted; BTB kept as full PCs per slot.
  logic [31:0] m_pc;
  int m_mode;
  bit m_mis;
  bit m_v [N];
  logic [31:0] m_bpc [N];
  logic [31:0] m_btg [N];

  function automatic int slot(input logic [31:0] pc);
    return int'((pc / 4) % N);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return BTB && m_v[slot(pc)] && (m_bpc[slot(pc)] / (4 * N) == pc / (4 * N));
  endfunction

  task automatic idle();
    bus.EN = 1'b1; bus.PCSrcE = 1'b0; bus.PCTargetE = '0; bus.trap_i = 1'b0; bus.trap_vec_i = '0;
    bus.halt_i = 1'b0; bus.resume_i = 1'b0; bus.upd_valid_i = 1'b0; bus.upd_pc_i = '0;
    bus.upd_tgt_i = '0; bus.upd_taken_i = 1'b0;
  endtask

  task automatic tick();
    logic [31:0] npc;
    int nmode;
    bit nmis;
    npc = m_pc; nmode = m_mode; nmis = 1'b0;
    if (reset) begin
      npc = 32'h0; nmode = 0;
      for (int k = 0; k < N; k++) m_v[k] = 1'b0;
    end else begin
      if (m_mode == 0) nmode = 1;
      else if (bus.trap_i) begin
        npc = bus.trap_vec_i - bus.trap_vec_i % 4; nmis = (bus.trap_vec_i % 4) != 0;
      end else begin
        if (bus.PCSrcE) begin
          npc = bus.PCTargetE - bus.PCTargetE % 4; nmis = (bus.PCTargetE % 4) != 0;
        end else if (m_mode == 1 && bus.halt_i) nmode = 2;
        else if (m_mode == 1 && bus.EN) npc = m_hit(m_pc) ? m_btg[slot(m_pc)] : m_pc + 4;
        if (m_mode == 2 && bus.resume_i) nmode = 1;
      end
      if (BTB && bus.upd_valid_i) begin
        if (bus.upd_taken_i) begin
          m_v[slot(bus.upd_pc_i)] = 1'b1;
          m_bpc[slot(bus.upd_pc_i)] = bus.upd_pc_i;
          m_btg[slot(bus.upd_pc_i)] = bus.upd_tgt_i;
        end else if (m_bpc[slot(bus.upd_pc_i)] / (4 * N) == bus.upd_pc_i / (4 * N)) begin
          m_v[slot(bus.upd_pc_i)] = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    m_pc = npc; m_mode = nmode; m_mis = nmis;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc [3];
    exp_pc = '{32'h0, 32'h4, 32'h8};
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_checks++; if (bus.PCF !== 32'h0) begin n_errors++; $display("FAIL reset_pc: got %h exp %h", bus.PCF, 32'h0); end
    n_checks++; if (bus.PCPlus4F !== 32'h4) begin n_errors++; $display("FAIL reset_pcplus4: got %h exp %h", bus.PCPlus4F, 32'h4); end
    n_checks++; if (bus.fetch_vld_o !== 1'b0) begin n_errors++; $display("FAIL reset_vld: got %b exp 0", bus.fetch_vld_o); end
    n_checks++; if (bus.halted_o !== 1'b0) begin n_errors++; $display("FAIL reset_halted: got %b exp 0", bus.halted_o); end
    n_checks++; if (bus.misalign_o !== 1'b0) begin n_errors++; $display("FAIL reset_misalign: got %b exp 0", bus.misalign_o); end
    n_checks++; if (bus.pred_taken_o !== 1'b0) begin n_errors++; $display("FAIL reset_pred: got %b exp 0", bus.pred_taken_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.PCF !== exp_pc[i]) begin n_errors++; $display("FAIL boot_seq_pc[%0d]: got %h exp %h", i, bus.PCF, exp_pc[i]); end
      n_checks++; if (bus.fetch_vld_o !== 1'b1) begin n_errors++; $display("FAIL boot_seq_vld[%0d]: got %b exp 1", i, bus.fetch_vld_o); end
    end
  endtask

  task automatic test_stall_redirect();
    bus.EN = 1'b0; bus.PCSrcE = 1'b1; bus.PCTargetE = 32'h100;
    tick();
    bus.PCSrcE = 1'b0;
    n_checks++; if (bus.PCF !== 32'h100) begin n_errors++; $display("FAIL stall_redirect_pc: got %h exp %h", bus.PCF, 32'h100); end
    n_checks++; if (bus.fetch_vld_o !== 1'b0) begin n_errors++; $display("FAIL stall_vld: got %b exp 0", bus.fetch_vld_o); end
    tick();
    n_checks++; if (bus.PCF !== 32'h100) begin n_errors++; $display("FAIL stall_hold_pc: got %h exp %h", bus.PCF, 32'h100); end
    bus.EN = 1'b1;
  endtask

  task automatic test_trap_priority();
    bus.trap_i = 1'b1; bus.trap_vec_i = 32'h80; bus.PCSrcE = 1'b1; bus.PCTargetE = 32'h200;
    tick();
    idle();
    n_checks++; if (bus.PCF !== 32'h80) begin n_errors++; $display("FAIL trap_priority_pc: got %h exp %h", bus.PCF, 32'h80); end
    n_checks++; if (bus.misalign_o !== 1'b0) begin n_errors++; $display("FAIL trap_misalign: got %b exp 0", bus.misalign_o); end
  endtask

  task automatic test_misalign();
    bus.PCSrcE = 1'b1; bus.PCTargetE = 32'h102;
    tick();
    idle();
    n_checks++; if (bus.PCF !== 32'h100) begin n_errors++; $display("FAIL misalign_pc: got %h exp %h", bus.PCF, 32'h100); end
    n_checks++; if (bus.misalign_o !== 1'b1) begin n_errors++; $display("FAIL misalign_pulse: got %b exp 1", bus.misalign_o); end
    tick();
    n_checks++; if (bus.misalign_o !== 1'b0) begin n_errors++; $display("FAIL misalign_clear: got %b exp 0", bus.misalign_o); end
    n_checks++; if (bus.PCF !== 32'h104) begin n_errors++; $display("FAIL misalign_next_pc: got %h exp %h", bus.PCF, 32'h104); end
  endtask

  task automatic test_halt();
    bus.PCSrcE = 1'b1; bus.PCTargetE = 32'h20;
    tick();
    idle();
    bus.halt_i = 1'b1;
    tick();
    bus.halt_i = 1'b0;
    n_checks++; if (bus.PCF !== 32'h20) begin n_errors++; $display("FAIL halt_pc: got %h exp %h", bus.PCF, 32'h20); end
    n_checks++; if (bus.halted_o !== 1'b1) begin n_errors++; $display("FAIL halt_flag: got %b exp 1", bus.halted_o); end
    n_checks++; if (bus.fetch_vld_o !== 1'b0) begin n_errors++; $display("FAIL halt_vld: got %b exp 0", bus.fetch_vld_o); end
    tick();
    n_checks++; if (bus.PCF !== 32'h20) begin n_errors++; $display("FAIL halt_hold_pc: got %h exp %h", bus.PCF, 32'h20); end
    bus.halt_i = 1'b1; bus.resume_i = 1'b1;
    tick();
    idle();
    n_checks++; if (bus.halted_o !== 1'b0) begin n_errors++; $display("FAIL resume_wins: got %b exp 0", bus.halted_o); end
    tick();
    n_checks++; if (bus.PCF !== 32'h24) begin n_errors++; $display("FAIL resume_pc: got %h exp %h", bus.PCF, 32'h24); end
    bus.halt_i = 1'b1;
    tick();
    bus.halt_i = 1'b0; bus.PCSrcE = 1'b1; bus.PCTargetE = 32'h300;
    tick();
    bus.PCSrcE = 1'b0;
    n_checks++; if (bus.PCF !== 32'h300) begin n_errors++; $display("FAIL halt_redirect_pc: got %h exp %h", bus.PCF, 32'h300); end
    n_checks++; if (bus.halted_o !== 1'b1) begin n_errors++; $display("FAIL halt_redirect_flag: got %b exp 1", bus.halted_o); end
    bus.resume_i = 1'b1;
    tick();
    idle();
    tick();
    n_checks++; if (bus.PCF !== 32'h304) begin n_errors++; $display("FAIL halt_redirect_resume_pc: got %h exp %h", bus.PCF, 32'h304); end
  endtask

  task automatic test_wrap();
    bus.PCSrcE = 1'b1; bus.PCTargetE = 32'hFFFF_FFFC;
    tick();
    idle();
    n_checks++; if (bus.PCPlus4F !== 32'h0) begin n_errors++; $display("FAIL wrap_pcplus4: got %h exp %h", bus.PCPlus4F, 32'h0); end
    tick();
    n_checks++; if (bus.PCF !== 32'h0) begin n_errors++; $display("FAIL wrap_pc: got %h exp %h", bus.PCF, 32'h0); end
  endtask

  task automatic test_btb();
    logic [31:0] exp_next;
    exp_next = BTB ? 32'h400 : 32'h44;
    bus.upd_valid_i = 1'b1; bus.upd_pc_i = 32'h40; bus.upd_tgt_i = 32'h400; bus.upd_taken_i = 1'b1;
    bus.PCSrcE = 1'b1; bus.PCTargetE = 32'h40;
    tick();
    idle();
    n_checks++; if (bus.pred_taken_o !== BTB) begin n_errors++; $display("FAIL btb_hit: got %b exp %b", bus.pred_taken_o, BTB); end
    tick();
    n_checks++; if (bus.PCF !== exp_next) begin n_errors++; $display("FAIL btb_pred_pc: got %h exp %h", bus.PCF, exp_next); end
    bus.upd_valid_i = 1'b1; bus.upd_pc_i = 32'h40; bus.upd_taken_i = 1'b0;
    bus.PCSrcE = 1'b1; bus.PCTargetE = 32'h40;
    tick();
    idle();
    n_checks++; if (bus.pred_taken_o !== 1'b0) begin n_errors++; $display("FAIL btb_cleared: got %b exp 0", bus.pred_taken_o); end
    tick();
    n_checks++; if (bus.PCF !== 32'h44) begin n_errors++; $display("FAIL btb_cleared_pc: got %h exp %h", bus.PCF, 32'h44); end
  endtask

  task automatic test_random();
    bit exp_vld;
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 63) == 0);
      bus.EN = ($urandom_range(0, 3) != 0);
      bus.trap_i = ($urandom_range(0, 15) == 0);
      bus.trap_vec_i = $urandom_range(0, 511);
      bus.PCSrcE = ($urandom_range(0, 7) == 0);
      bus.PCTargetE = $urandom_range(0, 511);
      bus.halt_i = ($urandom_range(0, 15) == 0);
      bus.resume_i = ($urandom_range(0, 3) == 0);
      bus.upd_valid_i = ($urandom_range(0, 1) == 0);
      bus.upd_pc_i = 32'($urandom_range(0, 127)) * 4;
      bus.upd_tgt_i = 32'($urandom_range(0, 127)) * 4;
      bus.upd_taken_i = ($urandom_range(0, 2) != 0);
      tick();
      exp_vld = (m_mode == 1) && bus.EN;
      n_checks++; if (bus.PCF !== m_pc) begin n_errors++; $display("FAIL rand_pc[%0d]: got %h exp %h", c, bus.PCF, m_pc); end
      n_checks++; if (bus.PCPlus4F !== m_pc + 32'd4) begin n_errors++; $display("FAIL rand_pcplus4[%0d]: got %h exp %h", c, bus.PCPlus4F, m_pc + 32'd4); end
      n_checks++; if (bus.fetch_vld_o !== exp_vld) begin n_errors++; $display("FAIL rand_vld[%0d]: got %b exp %b", c, bus.fetch_vld_o, exp_vld); end
      n_checks++; if (bus.halted_o !== (m_mode == 2)) begin n_errors++; $display("FAIL rand_halted[%0d]: got %b exp %b", c, bus.halted_o, m_mode == 2); end
      n_checks++; if (bus.misalign_o !== m_mis) begin n_errors++; $display("FAIL rand_misalign[%0d]: got %b exp %b", c, bus.misalign_o, m_mis); end
      n_checks++; if (bus.pred_taken_o !== m_hit(m_pc)) begin n_errors++; $display("FAIL rand_pred[%0d]: got %b exp %b", c, bus.pred_taken_o, m_hit(m_pc)); end
    end
    reset = 1'b0;
    idle();
  endtask

  initial begin
    m_pc = '0; m_mode = 0; m_mis = 1'b0;
    for (int k = 0; k < N; k++) begin m_v[k] = 1'b0; m_bpc[k] = '0; m_btg[k] = '0; end
    reset = 1'b1;
    idle();
    test_reset();
    test_stall_redirect();
    test_trap_priority();
    test_misalign();
    test_halt();
    test_wrap();
    test_btb();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
